// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared ARF/IR control encodings and fetch FSM states.
package fetch_sequencer_pkg;
  localparam logic [1:0] FS_DEC = 2'b00;
  localparam logic [1:0] FS_INC = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR = 2'b11;
  localparam logic [3:0] ARF_SEL_PC = 4'b1000;
  localparam logic [3:0] ARF_SEL_NONE = 4'b0000;
  localparam logic [1:0] OSEL_PC = 2'b00;
  typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, PRESENT, FAULT} state_t;
  function automatic logic is_fetch(input state_t s);
    return s == FETCH_LO || s == FETCH_HI;
  endfunction
endpackage

// File: rtl/fetch_timeout_timer.sv
// fetch_timeout_timer: counts unacknowledged request cycles, flags the last allowed one.
module fetch_timeout_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  assign term = inc && cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-byte instruction fetch into the IR with decode handshake, flush and timeout fault.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             flush,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [1:0]       arf_outdsel,
  output logic [3:0]       arf_regsel,
  output logic [1:0]       arf_funsel,
  output logic             ir_en,
  output logic             ir_lh,
  output logic [1:0]       ir_funsel,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             fault,
  output logic             busy
);
  state_t state, state_n;
  logic inc, term;
  // inc comes straight from state and inputs so the timer never loops through the FSM decode
  assign inc = is_fetch(state) && !flush && !mem_ack;
  fetch_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(!inc || state_n != state), .inc(inc), .term(term)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fetch_cnt <= '0;
    end else begin
      state <= state_n;
      if (instr_valid && instr_ready) fetch_cnt <= fetch_cnt + 1'b1;
    end
  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    arf_outdsel = OSEL_PC;
    arf_regsel = ARF_SEL_NONE;
    arf_funsel = 2'b00;
    ir_en = 1'b0;
    ir_lh = 1'b0;
    ir_funsel = 2'b00;
    instr_valid = 1'b0;
    fault = 1'b0;
    case (state)
      IDLE: state_n = start ? FETCH_LO : IDLE;
      FETCH_LO, FETCH_HI: begin
        mem_req = !flush;
        ir_lh = state == FETCH_HI;
        // flush beats a same-cycle ack: no IR load, no PC increment
        if (flush) state_n = FETCH_LO;
        else if (mem_ack) begin
          ir_en = 1'b1;
          ir_funsel = FS_LOAD;
          arf_regsel = ARF_SEL_PC;
          arf_funsel = FS_INC;
          state_n = state == FETCH_LO ? FETCH_HI : PRESENT;
        end else if (term) state_n = FAULT;
      end
      PRESENT: begin
        instr_valid = !flush;
        state_n = flush ? FETCH_LO : !instr_ready ? PRESENT : halt ? IDLE : FETCH_LO;
      end
      FAULT: begin
        fault = 1'b1;
        state_n = start ? FETCH_LO : FAULT;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = state inside {FETCH_LO, FETCH_HI, PRESENT};
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch, backpressure, flush, timeout, wrap/halt and async reset.
module tb_fetch_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, halt = 0, flush = 0, mem_ack = 0, instr_ready = 0;
  logic mem_req, ir_en, ir_lh, instr_valid, fault, busy;
  logic [1:0] arf_outdsel, arf_funsel, ir_funsel;
  logic [3:0] arf_regsel;
  logic [7:0] fetch_cnt;
  int npass = 0, ntotal = 0, pc_inc = 0, ir_loads = 0;

  fetch_sequencer #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .flush(flush),
    .mem_req(mem_req), .mem_ack(mem_ack), .arf_outdsel(arf_outdsel),
    .arf_regsel(arf_regsel), .arf_funsel(arf_funsel), .ir_en(ir_en), .ir_lh(ir_lh),
    .ir_funsel(ir_funsel), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_cnt(fetch_cnt), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arf_regsel == 4'b1000 && arf_funsel == 2'b01) pc_inc <= pc_inc + 1;
    if (ir_en) ir_loads <= ir_loads + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_regsel", {28'd0, arf_regsel}, 0);
    chk("rst_ir_en", {31'd0, ir_en}, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_cnt", {24'd0, fetch_cnt}, 0);
    chk("rst_busy_fault", {30'd0, busy, fault}, 0);
    rst_n = 1;
    start = 1; mem_ack = 1; instr_ready = 1;
    tick();
    start = 0;
    chk("lo_mem_req", {31'd0, mem_req}, 1);
    chk("lo_ir", {28'd0, ir_en, ir_lh, ir_funsel}, 32'b1010);
    chk("lo_pc", {26'd0, arf_regsel, arf_funsel}, 32'b100001);
    chk("lo_busy", {31'd0, busy}, 1);
    tick();
    chk("hi_ir", {28'd0, ir_en, ir_lh, ir_funsel}, 32'b1110);
    chk("hi_mem_req", {31'd0, mem_req}, 1);
    tick();
    chk("pres_valid", {31'd0, instr_valid}, 1);
    chk("pres_idle_ctl", {26'd0, mem_req, ir_en, arf_regsel}, 0);
    tick();
    chk("cnt_after_first", {24'd0, fetch_cnt}, 1);
    chk("back_to_lo", {30'd0, mem_req, ir_lh}, 32'b10);
    chk("pc_inc_first", pc_inc, 2);
    instr_ready = 0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, instr_valid}, 1);
      chk("bp_quiet", {26'd0, mem_req, ir_en, arf_regsel}, 0);
      tick();
    end
    chk("bp_cnt_held", {24'd0, fetch_cnt}, 1);
    instr_ready = 1;
    tick();
    chk("bp_cnt_acc", {24'd0, fetch_cnt}, 2);
    chk("pc_inc_bp", pc_inc, 4);
    tick();
    flush = 1;
    #1;
    chk("flush_hi_ir_en", {31'd0, ir_en}, 0);
    chk("flush_hi_regsel", {28'd0, arf_regsel}, 0);
    chk("flush_hi_mem_req", {31'd0, mem_req}, 0);
    tick();
    flush = 0;
    #1;
    chk("flush_to_lo", {30'd0, mem_req, ir_lh}, 32'b10);
    chk("flush_cnt", {24'd0, fetch_cnt}, 2);
    tick();
    tick();
    flush = 1;
    #1;
    chk("flush_pres_valid", {31'd0, instr_valid}, 0);
    tick();
    flush = 0;
    mem_ack = 0;
    #1;
    chk("flush_pres_cnt", {24'd0, fetch_cnt}, 2);
    chk("flush_pres_lo", {30'd0, mem_req, ir_lh}, 32'b10);
    for (int i = 0; i < 14; i++) tick();
    chk("to_still_wait", {29'd0, mem_req, busy, fault}, 32'b110);
    tick();
    chk("to_fault", {29'd0, mem_req, busy, fault}, 32'b001);
    flush = 1;
    tick();
    flush = 0;
    chk("fault_flush_ign", {30'd0, busy, fault}, 32'b01);
    chk("pc_inc_fault", pc_inc, 7);
    start = 1;
    tick();
    start = 0;
    mem_ack = 1;
    #1;
    chk("restart", {29'd0, mem_req, busy, fault}, 32'b110);
    halt = 1;
    tick();
    halt = 0;
    chk("halt_ign_hi", {30'd0, mem_req, ir_lh}, 32'b11);
    tick();
    tick();
    chk("cnt_3", {24'd0, fetch_cnt}, 3);
    for (int i = 0; i < 252; i++) begin tick(); tick(); tick(); end
    chk("cnt_255", {24'd0, fetch_cnt}, 255);
    tick();
    tick();
    halt = 1;
    tick();
    halt = 0;
    chk("wrap_cnt", {24'd0, fetch_cnt}, 0);
    chk("halt_idle", {30'd0, busy, mem_req}, 0);
    tick();
    tick();
    chk("halt_no_req", {30'd0, busy, mem_req}, 0);
    chk("pc_inc_total", pc_inc, 515);
    chk("ir_loads_total", ir_loads, 515);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("pre_rst_hi", {30'd0, mem_req, ir_lh}, 32'b11);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ctl", {25'd0, mem_req, ir_en, busy, arf_regsel}, 0);
    chk("async_rst_cnt", {24'd0, fetch_cnt}, 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
